// File: rtl/expr_eval_if.sv
// Character-stream bus between a character source and the expression evaluator.
// Carries the qualified 8-bit character in one direction and the evaluator's
// registered status (out, result, err) back in the other.
//   in_valid/in : character and its qualifier, driven by the source
//   out/result/err : evaluation status, driven by the evaluator
interface expr_eval_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [7:0]   in;
    logic         out;
    logic [W-1:0] result;
    logic         err;

    // Character source side.
    modport master (
        output in_valid,
        output in,
        input  out,
        input  result,
        input  err
    );

    // Evaluator side.
    modport slave (
        input  in_valid,
        input  in,
        output out,
        output result,
        output err
    );
endinterface

// File: rtl/expr_eval.sv
// Evaluates an ASCII stream digit (op digit)* with '*' binding tighter than '+'.
// Latency 1 cycle: outputs are registered on the edge that consumes a character.
// No backpressure: a character is taken on every edge with in_valid=1.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   bus : expr_eval_if.slave (in_valid, in -> out, result, err)
module expr_eval #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        clr,
    expr_eval_if.slave  bus
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_NUM   = 3'd1,
        S_ADD   = 3'd2,
        S_MUL   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t       state;
    state_t       nxt_state;
    logic [W-1:0] acc;
    logic [W-1:0] term;
    logic [W-1:0] nxt_acc;
    logic [W-1:0] nxt_term;
    logic         is_digit;
    logic [W-1:0] dig;

    // For '0'..'9' the digit value is exactly the low nibble of the code.
    assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    assign dig      = W'(bus.in[3:0]);

    always_comb begin
        nxt_state = state;
        nxt_acc   = acc;
        nxt_term  = term;
        case (state)
            S_START: begin
                if (is_digit) begin
                    nxt_acc   = '0;
                    nxt_term  = dig;
                    nxt_state = S_NUM;
                end else begin
                    nxt_state = S_ERR;
                end
            end
            S_NUM: begin
                if (bus.in == 8'h2B) begin
                    // A '+' closes the current term into the running sum.
                    nxt_acc   = acc + term;
                    nxt_state = S_ADD;
                end else if (bus.in == 8'h2A) begin
                    nxt_state = S_MUL;
                end else begin
                    // Includes a second digit: multi-digit numbers are illegal.
                    nxt_state = S_ERR;
                end
            end
            S_ADD: begin
                if (is_digit) begin
                    nxt_term  = dig;
                    nxt_state = S_NUM;
                end else begin
                    nxt_state = S_ERR;
                end
            end
            S_MUL: begin
                if (is_digit) begin
                    // Low W bits of the product do not depend on the upper bits,
                    // so a W-wide multiply gives the truncated full product.
                    nxt_term  = term * dig;
                    nxt_state = S_NUM;
                end else begin
                    nxt_state = S_ERR;
                end
            end
            default: begin
                nxt_state = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_START;
            acc        <= '0;
            term       <= '0;
            bus.out    <= 1'b0;
            bus.result <= '0;
            bus.err    <= 1'b0;
        end else if (bus.in_valid) begin
            state <= nxt_state;
            acc   <= nxt_acc;
            term  <= nxt_term;
            case (nxt_state)
                S_NUM: begin
                    bus.out    <= 1'b1;
                    bus.result <= nxt_acc + nxt_term;
                end
                S_ERR: begin
                    bus.out    <= 1'b0;
                    bus.result <= '0;
                    bus.err    <= 1'b1;
                end
                default: begin
                    // Operator pending: prefix incomplete, keep last result.
                    bus.out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a W=32 instance checks most vectors and a W=8
// instance, fed the same characters, checks modulo-2^W wrap of the product.
module tb_expr_eval;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    expr_eval_if #(.W(32)) bus32 ();
    expr_eval_if #(.W(8))  bus8 ();

    expr_eval #(.W(32)) dut32 (.clk(clk), .clr(clr), .bus(bus32.slave));
    expr_eval #(.W(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one character to both instances, consume it on the next edge,
    // and return 1 time unit after that edge for sampling.
    task automatic step(input logic v, input logic [7:0] c);
        bus32.in_valid = v;
        bus32.in       = c;
        bus8.in_valid  = v;
        bus8.in        = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus32.in_valid = 1'b0;
        bus8.in_valid  = 1'b0;
        @(posedge clk);
        #2 clr = 1'b1;
        #4 clr = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] c, input string tag,
                            input logic eo, input logic [31:0] er, input logic ee);
        step(1'b1, c);
        chk({tag, ".out"},    32'(bus32.out),  32'(eo));
        chk({tag, ".result"}, bus32.result,    er);
        chk({tag, ".err"},    32'(bus32.err),  32'(ee));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        bus32.in_valid = 1'b0;
        bus32.in       = 8'h00;
        bus8.in_valid  = 1'b0;
        bus8.in        = 8'h00;
        #12;
        chk("rst.out",    32'(bus32.out), 32'd0);
        chk("rst.result", bus32.result,   32'd0);
        chk("rst.err",    32'(bus32.err), 32'd0);
        clr = 1'b0;

        // "1+2*3"
        send_chk("1", "a1", 1'b1, 32'd1, 1'b0);
        send_chk("+", "a2", 1'b0, 32'd1, 1'b0);
        send_chk("2", "a3", 1'b1, 32'd3, 1'b0);
        send_chk("*", "a4", 1'b0, 32'd3, 1'b0);
        send_chk("3", "a5", 1'b1, 32'd7, 1'b0);

        // "2*3+4*5"
        do_reset();
        send_chk("2", "b1", 1'b1, 32'd2,  1'b0);
        send_chk("*", "b2", 1'b0, 32'd2,  1'b0);
        send_chk("3", "b3", 1'b1, 32'd6,  1'b0);
        send_chk("+", "b4", 1'b0, 32'd6,  1'b0);
        send_chk("4", "b5", 1'b1, 32'd10, 1'b0);
        send_chk("*", "b6", 1'b0, 32'd10, 1'b0);
        send_chk("5", "b7", 1'b1, 32'd26, 1'b0);

        // "9*9*9*9" on the 8-bit instance: 9, 81, 729%256=217, 6561%256=161
        do_reset();
        step(1'b1, "9"); chk("w1", 32'(bus8.result), 32'd9);
        step(1'b1, "*");
        step(1'b1, "9"); chk("w2", 32'(bus8.result), 32'd81);
        step(1'b1, "*");
        step(1'b1, "9"); chk("w3", 32'(bus8.result), 32'd217);
        step(1'b1, "*");
        step(1'b1, "9"); chk("w4", 32'(bus8.result), 32'd161);
        chk("w4.out", 32'(bus8.out), 32'd1);
        chk("w32", bus32.result, 32'd6561);

        // "*" then a digit
        do_reset();
        send_chk("*", "e1", 1'b0, 32'd0, 1'b1);
        send_chk("1", "e1d", 1'b0, 32'd0, 1'b1);

        // "12"
        do_reset();
        send_chk("1", "e2a", 1'b1, 32'd1, 1'b0);
        send_chk("2", "e2b", 1'b0, 32'd0, 1'b1);

        // "1++" then a digit
        do_reset();
        send_chk("1", "e3a", 1'b1, 32'd1, 1'b0);
        send_chk("+", "e3b", 1'b0, 32'd1, 1'b0);
        send_chk("+", "e3c", 1'b0, 32'd0, 1'b1);
        send_chk("7", "e3d", 1'b0, 32'd0, 1'b1);

        // "3a" then a digit
        do_reset();
        send_chk("3", "e4a", 1'b1, 32'd3, 1'b0);
        send_chk("a", "e4b", 1'b0, 32'd0, 1'b1);
        send_chk("4", "e4c", 1'b0, 32'd0, 1'b1);

        // "4", stall 3 cycles with '*' on the bus, then "*5"
        do_reset();
        send_chk("4", "s0", 1'b1, 32'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "*");
            chk("stall.out",    32'(bus32.out), 32'd1);
            chk("stall.result", bus32.result,   32'd4);
        end
        send_chk("*", "s1", 1'b0, 32'd4,  1'b0);
        send_chk("5", "s2", 1'b1, 32'd20, 1'b0);

        // "3*", asynchronous clear between edges, then "5"
        do_reset();
        send_chk("3", "r1", 1'b1, 32'd3, 1'b0);
        send_chk("*", "r2", 1'b0, 32'd3, 1'b0);
        bus32.in_valid = 1'b0;
        bus8.in_valid  = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("async.out",    32'(bus32.out), 32'd0);
        chk("async.result", bus32.result,   32'd0);
        chk("async.err",    32'(bus32.err), 32'd0);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b1;
        bus32.in       = "9";
        @(posedge clk);
        #1;
        chk("hold.result", bus32.result, 32'd0);
        bus32.in_valid = 1'b0;
        #2 clr = 1'b0;
        send_chk("5", "r3", 1'b1, 32'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
